// File: rtl/fpu_sequencer.sv
// In-order FP co-processor scheduler: queues CPU ops, issues to add/mul/trig, retires in request order.
// Latency: strobe -> unit start 2 cycles; unit done -> done output 2 cycles when oldest.
// Backpressure: cpu_hold while the command queue is full; strobes under hold are dropped.
module fpu_sequencer #(
    parameter int QDEPTH = 4,
    parameter int PTR_W  = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        op_strobe,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  op_sel,
    output logic        cpu_hold,
    output logic        err_opcode,
    output logic [31:0] unit_op1,
    output logic [31:0] unit_op2,
    output logic        sub_sel,
    output logic        add_start,
    output logic        mul_start,
    output logic        sine_start,
    input  logic        add_done,
    input  logic        mul_done,
    input  logic        sine_done,
    input  logic [31:0] add_result,
    input  logic [31:0] mul_result,
    input  logic [31:0] sine_result,
    input  logic [31:0] cosine_result,
    input  logic        add_overflow,
    input  logic        mul_overflow,
    output logic [31:0] result,
    output logic        done,
    output logic        overflow
);
    localparam int            CW     = PTR_W + 1;
    localparam logic [CW-1:0] FULL   = CW'(QDEPTH);
    localparam logic [1:0]    U_ADD  = 2'd0;
    localparam logic [1:0]    U_MUL  = 2'd1;
    localparam logic [1:0]    U_TRIG = 2'd2;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    typedef struct packed {
        logic [1:0] unit;
        logic       cos;
    } tag_t;

    cmd_t             cmd_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    tag_t             ord_q [3];
    logic [1:0]       ord_wr, ord_rd, ord_cnt;
    logic [2:0]       busy, hold_vld, hold_ovf;   // bit index is the unit id
    logic [31:0]      hold_res [3];
    logic [31:0]      hold_cos;

    cmd_t       head;
    tag_t       ord_head;
    logic [1:0] head_unit;
    logic       enq, deq, ret;
    logic [2:0] cap, disp_mask, ret_mask;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        head     = cmd_q[rd_ptr];
        ord_head = ord_q[ord_rd];
        case (head.sel)
            3'b000, 3'b001: head_unit = U_ADD;
            3'b010:         head_unit = U_MUL;
            default:        head_unit = U_TRIG;
        endcase
        enq       = op_strobe && (op_sel <= 3'd4) && !cpu_hold;
        deq       = (count != '0) && !busy[head_unit] && (ord_cnt != 2'd3);
        ret       = (ord_cnt != 2'd0) && hold_vld[ord_head.unit];
        // a done pulse only counts for a unit that has an uncaptured op in flight
        cap       = {sine_done, mul_done, add_done} & busy & ~hold_vld;
        disp_mask = deq ? (3'b001 << head_unit) : 3'b000;
        ret_mask  = ret ? (3'b001 << ord_head.unit) : 3'b000;
        count_nxt = count + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk) begin
        if (enq) cmd_q[wr_ptr] <= {op_sel, op1, op2};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cpu_hold   <= 1'b0;
            err_opcode <= 1'b0;
            ord_wr     <= 2'd0;
            ord_rd     <= 2'd0;
            ord_cnt    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                ord_q[i]    <= '0;
                hold_res[i] <= '0;
            end
            hold_cos   <= '0;
            busy       <= '0;
            hold_vld   <= '0;
            hold_ovf   <= '0;
            unit_op1   <= '0;
            unit_op2   <= '0;
            sub_sel    <= 1'b0;
            add_start  <= 1'b0;
            mul_start  <= 1'b0;
            sine_start <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            err_opcode <= op_strobe && (op_sel > 3'd4);
            count      <= count_nxt;
            cpu_hold   <= (count_nxt == FULL);
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);

            add_start  <= deq && (head_unit == U_ADD);
            mul_start  <= deq && (head_unit == U_MUL);
            sine_start <= deq && (head_unit == U_TRIG);
            if (deq) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                unit_op1      <= head.a;
                unit_op2      <= head.b;
                sub_sel       <= (head.sel == 3'b001);
                ord_q[ord_wr] <= {head_unit, head.sel == 3'b100};
                ord_wr        <= inc3(ord_wr);
            end

            done <= ret;
            if (ret) begin
                result   <= (ord_head.unit == U_TRIG && ord_head.cos) ? hold_cos
                                                                       : hold_res[ord_head.unit];
                overflow <= hold_ovf[ord_head.unit];
                ord_rd   <= inc3(ord_rd);
            end
            ord_cnt  <= ord_cnt + 2'(deq) - 2'(ret);
            // a unit stays reserved until its result has left, not merely finished
            busy     <= (busy | disp_mask) & ~ret_mask;
            hold_vld <= (hold_vld | cap) & ~ret_mask;

            if (cap[0]) begin
                hold_res[0] <= add_result;
                hold_ovf[0] <= add_overflow;
            end
            if (cap[1]) begin
                hold_res[1] <= mul_result;
                hold_ovf[1] <= mul_overflow;
            end
            if (cap[2]) begin
                hold_res[2] <= sine_result;
                hold_cos    <= cosine_result;
                hold_ovf[2] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: plays the three arithmetic units and checks in-order issue/retire against a queue model.
module tb_fpu_sequencer;
    localparam int QD = 4;

    logic        clk = 1'b0, n_rst = 1'b0;
    logic        op_strobe = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [2:0]  op_sel = '0;
    logic        cpu_hold, err_opcode, sub_sel, add_start, mul_start, sine_start, done, overflow;
    logic [31:0] unit_op1, unit_op2, result;
    logic        add_done = 1'b0, mul_done = 1'b0, sine_done = 1'b0;
    logic        add_overflow = 1'b0, mul_overflow = 1'b0;
    logic [31:0] add_result = '0, mul_result = '0, sine_result = '0, cosine_result = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_sequencer #(.QDEPTH(QD), .PTR_W(2)) dut (
        .clk(clk), .n_rst(n_rst), .op_strobe(op_strobe), .op1(op1), .op2(op2), .op_sel(op_sel),
        .cpu_hold(cpu_hold), .err_opcode(err_opcode), .unit_op1(unit_op1), .unit_op2(unit_op2),
        .sub_sel(sub_sel), .add_start(add_start), .mul_start(mul_start), .sine_start(sine_start),
        .add_done(add_done), .mul_done(mul_done), .sine_done(sine_done),
        .add_result(add_result), .mul_result(mul_result), .sine_result(sine_result),
        .cosine_result(cosine_result), .add_overflow(add_overflow), .mul_overflow(mul_overflow),
        .result(result), .done(done), .overflow(overflow)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct {
        int          unit;
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    req_t        pend_q[$];          // accepted, not yet issued
    exp_t        ret_q[$];           // issued, awaiting retire, in request order
    int          st_cyc[$], st_unit[$], dn_cyc[$];
    logic [31:0] dn_res[$];
    int          cyc = 0, n_acc = 0, n_err = 0, last_acc = 0;
    int          cd[3], fixed_lat[3], drv_cyc[3];
    bit          stall[3], stray[3], inflight[3], force_en[3], pend_cos[3];
    logic [31:0] force_res[3], pend_res[3], pend_alt[3];
    logic        pend_ovf[3];
    logic        exp_err = 1'b0;
    logic [31:0] last_res = '0;
    logic        last_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic on_start(input int u);
        req_t r;
        exp_t e;
        int   want;
        st_cyc.push_back(cyc);
        st_unit.push_back(u);
        check("start_unit_free", 32'(inflight[u]), 0);
        check("start_has_request", 32'(pend_q.size() != 0), 1);
        if (pend_q.size() == 0) return;
        r    = pend_q.pop_front();
        want = (r.sel <= 3'd1) ? 0 : (r.sel == 3'd2) ? 1 : 2;
        check("start_unit", u, want);
        check("unit_op1", unit_op1, r.a);
        if (u != 2) check("unit_op2", unit_op2, r.b);
        if (u == 0) check("sub_sel", 32'(sub_sel), 32'(r.sel == 3'd1));
        pend_res[u] = force_en[u] ? force_res[u] : $urandom;
        pend_alt[u] = $urandom;
        pend_ovf[u] = (u == 2 || force_en[u]) ? 1'b0 : 1'($urandom_range(0, 1));
        pend_cos[u] = (r.sel == 3'd4);
        inflight[u] = 1'b1;
        cd[u]       = (fixed_lat[u] != 0) ? fixed_lat[u] : int'($urandom_range(1, 6));
        e.unit = u;
        e.res  = pend_res[u];
        e.ovf  = pend_ovf[u];
        ret_q.push_back(e);
    endtask

    task automatic on_done();
        exp_t e;
        check("done_expected", 32'(ret_q.size() != 0), 1);
        dn_cyc.push_back(cyc);
        dn_res.push_back(result);
        last_res = result;
        last_ovf = overflow;
        if (ret_q.size() == 0) return;
        e = ret_q.pop_front();
        check("result", result, e.res);
        check("overflow", 32'(overflow), 32'(e.ovf));
        inflight[e.unit] = 1'b0;
    endtask

    task automatic drive_done(input int u, input logic [31:0] r, input logic [31:0] alt, input logic ov);
        case (u)
            0: begin add_done = 1'b1; add_result = r; add_overflow = ov; end
            1: begin mul_done = 1'b1; mul_result = r; mul_overflow = ov; end
            default: begin
                sine_done     = 1'b1;
                sine_result   = pend_cos[2] ? alt : r;
                cosine_result = pend_cos[2] ? r : alt;
            end
        endcase
    endtask

    always @(negedge clk) begin : monitor
        logic [2:0] st;
        cyc++;
        add_done  = 1'b0;
        mul_done  = 1'b0;
        sine_done = 1'b0;
        if (!n_rst) begin
            pend_q.delete();
            ret_q.delete();
            exp_err  = 1'b0;
            last_res = '0;
            last_ovf = 1'b0;
            for (int u = 0; u < 3; u++) begin
                cd[u]       = 0;
                inflight[u] = 1'b0;
            end
        end else begin
            st = {sine_start, mul_start, add_start};
            check("one_start_per_cycle", 32'($countones(st) <= 1), 1);
            for (int u = 0; u < 3; u++) if (st[u]) on_start(u);
            if (done) on_done();
            else begin
                check("result_hold", result, last_res);
                check("overflow_hold", 32'(overflow), 32'(last_ovf));
            end
            check("cpu_hold", 32'(cpu_hold), 32'(pend_q.size() == QD));
            check("err_opcode", 32'(err_opcode), 32'(exp_err));
            if (err_opcode) n_err++;
            exp_err = op_strobe && (op_sel > 3'd4);
            if (op_strobe && op_sel <= 3'd4 && !cpu_hold) begin
                pend_q.push_back('{op_sel, op1, op2});
                n_acc++;
                last_acc = cyc;
            end
            for (int u = 0; u < 3; u++) begin
                if (stray[u]) begin
                    stray[u] = 1'b0;
                    drive_done(u, $urandom, $urandom, 1'b1);
                end else if (cd[u] > 0 && !stall[u]) begin
                    cd[u]--;
                    if (cd[u] == 0) begin
                        drv_cyc[u] = cyc;
                        drive_done(u, pend_res[u], pend_alt[u], pend_ovf[u]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        op_strobe = 1'b1;
        op_sel    = s;
        op1       = a;
        op2       = b;
        tick();
        op_strobe = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((pend_q.size() != 0 || ret_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < max), 1);
    endtask

    task automatic clear_logs();
        st_cyc.delete();
        st_unit.delete();
        dn_cyc.delete();
        dn_res.delete();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_cpu_hold"}, 32'(cpu_hold), 0);
        check({pfx, "_err_opcode"}, 32'(err_opcode), 0);
        check({pfx, "_starts"}, 32'({add_start, mul_start, sine_start}), 0);
        check({pfx, "_sub_sel"}, 32'(sub_sel), 0);
        check({pfx, "_unit_op1"}, unit_op1, 0);
        check({pfx, "_unit_op2"}, unit_op2, 0);
        check({pfx, "_result"}, result, 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_overflow"}, 32'(overflow), 0);
    endtask

    initial begin
        int a0;
        for (int u = 0; u < 3; u++) begin
            cd[u] = 0; fixed_lat[u] = 0; drv_cyc[u] = 0; stall[u] = 0; stray[u] = 0;
            inflight[u] = 0; force_en[u] = 0; force_res[u] = '0; pend_cos[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        tick();
        n_rst = 1'b1;
        tick();

        // single add: exact issue and retire latency
        clear_logs();
        fixed_lat[0] = 3; force_en[0] = 1; force_res[0] = 32'h4040_0000;
        strobe(3'b000, 32'h3F80_0000, 32'h4000_0000);
        wait_idle(60);
        check("add_starts", st_cyc.size(), 1);
        check("add_start_latency", st_cyc[0] - last_acc, 2);
        check("add_done_latency", dn_cyc[0] - drv_cyc[0], 2);
        check("add_result", result, 32'h4040_0000);
        check("add_overflow", 32'(overflow), 0);
        check("add_unit_op1", unit_op1, 32'h3F80_0000);
        check("add_unit_op2", unit_op2, 32'h4000_0000);

        // reorder: add finishes before the older mul, but retires after it
        clear_logs();
        fixed_lat[1] = 8; force_en[1] = 1; force_res[1] = 32'h40C0_0000;
        fixed_lat[0] = 1; force_res[0] = 32'h4000_0000;
        strobe(3'b010, 32'h4000_0000, 32'h4040_0000);
        strobe(3'b000, 32'h3F80_0000, 32'h3F80_0000);
        wait_idle(60);
        check("reorder_add_first", 32'(drv_cyc[0] < drv_cyc[1]), 1);
        check("reorder_dones", dn_res.size(), 2);
        check("reorder_first", dn_res[0], 32'h40C0_0000);
        check("reorder_second", dn_res[1], 32'h4000_0000);

        // structural hazard: second add issues the cycle after the first retires
        clear_logs();
        fixed_lat[0] = 3; fixed_lat[1] = 0; force_en[0] = 0; force_en[1] = 0;
        strobe(3'b000, $urandom, $urandom);
        strobe(3'b001, $urandom, $urandom);
        wait_idle(60);
        check("hazard_starts", st_cyc.size(), 2);
        check("hazard_dones", dn_cyc.size(), 2);
        check("hazard_reissue", st_cyc[1] - dn_cyc[0], 1);
        fixed_lat[0] = 0;

        // full queue: all units held busy, then five more strobes
        clear_logs();
        for (int u = 0; u < 3; u++) stall[u] = 1;
        a0 = n_acc;
        strobe(3'b000, $urandom, $urandom);
        strobe(3'b010, $urandom, $urandom);
        strobe(3'b011, $urandom, $urandom);
        strobe(3'b001, $urandom, $urandom);
        strobe(3'b010, $urandom, $urandom);
        strobe(3'b011, $urandom, $urandom);
        strobe(3'b100, $urandom, $urandom);
        strobe(3'b000, $urandom, $urandom);
        tick();
        check("full_cpu_hold", 32'(cpu_hold), 1);
        check("full_accepted", n_acc - a0, 7);
        check("full_starts_stalled", st_cyc.size(), 3);
        for (int u = 0; u < 3; u++) stall[u] = 0;
        wait_idle(200);
        check("full_starts", st_cyc.size(), 7);
        check("full_dones", dn_cyc.size(), 7);
        check("full_released", 32'(cpu_hold), 0);

        // cosine selection, then an invalid opcode
        clear_logs();
        force_en[2] = 1; force_res[2] = 32'h3F00_0000;
        strobe(3'b100, 32'h3F80_0000, 32'h0);
        wait_idle(60);
        check("cos_unit", st_unit[0], 2);
        check("cos_result", dn_res[0], 32'h3F00_0000);
        force_en[2] = 0;
        clear_logs();
        a0 = n_err;
        strobe(3'b110, $urandom, $urandom);
        repeat (4) tick();
        check("invalid_err_pulses", n_err - a0, 1);
        check("invalid_no_start", st_cyc.size(), 0);
        check("invalid_no_done", dn_cyc.size(), 0);

        // random traffic, strobes sometimes ignoring cpu_hold
        clear_logs();
        a0 = n_acc;
        for (int i = 0; i < 400; i++) begin
            op_strobe = ($urandom_range(0, 2) != 0);
            op_sel    = 3'($urandom_range(0, 7));
            op1       = $urandom;
            op2       = $urandom;
            tick();
        end
        op_strobe = 1'b0;
        wait_idle(400);
        check("random_all_retired", dn_cyc.size(), n_acc - a0);

        // reset with a mul busy and two queued
        clear_logs();
        stall[1] = 1;
        strobe(3'b010, $urandom | 32'h1, $urandom | 32'h1);
        strobe(3'b010, $urandom, $urandom);
        strobe(3'b010, $urandom, $urandom);
        repeat (3) tick();
        check("midflight_one_start", st_cyc.size(), 1);
        n_rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        stall[1] = 0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        clear_logs();
        stray[1] = 1;
        repeat (10) tick();
        check("stray_no_done", dn_cyc.size(), 0);
        check("stray_no_start", st_cyc.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
